// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer register file.
//   ADDR_WIDTH / DATA_WIDTH : bus widths
//   N                       : default register count
//   IDX_WIDTH               : width of the word index taken from the byte address
//   apb_slv_state_e         : completer FSM states
package apb_pkg;

    localparam int ADDR_WIDTH       = 32;
    localparam int DATA_WIDTH       = 32;
    localparam int N                = 16;
    localparam int WORD_OFFSET_BITS = 2;
    localparam int IDX_WIDTH        = ADDR_WIDTH - WORD_OFFSET_BITS;
    localparam int CNT_WIDTH        = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

endpackage

// File: rtl/apb_regfile.sv
// Register storage, index decode, access checks and read mux.
//   pclk, preset   : clock, async active-low reset
//   chk_addr_i     : byte address being decoded (setup phase)
//   chk_write_i    : direction of the access being decoded
//   chk_err_o      : misaligned, out of range, or write to read-only reg 0
//   rd_data_o      : read data for chk_addr_i (ID_VALUE for index 0)
//   wr_en_i        : commit wr_data_i into register wr_idx_i
//   wr_idx_i       : word index of the committed write
//   wr_data_i      : data of the committed write
//   regs_o         : flat copy of all registers, slice 0 = ID_VALUE
import apb_pkg::*;

module apb_regfile #(
    parameter int                    NUM_REGS = N,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA0B0_0001
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [ADDR_WIDTH-1:0]          chk_addr_i,
    input  logic                           chk_write_i,
    output logic                           chk_err_o,
    output logic [DATA_WIDTH-1:0]          rd_data_o,
    input  logic                           wr_en_i,
    input  logic [IDX_WIDTH-1:0]           wr_idx_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    // Register 0 is the constant ID, so only 1..NUM_REGS-1 get flops.
    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [IDX_WIDTH-1:0]  chk_idx;

    assign chk_idx = chk_addr_i[ADDR_WIDTH-1:WORD_OFFSET_BITS];

    always_comb begin
        chk_err_o = (|chk_addr_i[WORD_OFFSET_BITS-1:0])
                 || (chk_idx >= IDX_WIDTH'(NUM_REGS))
                 || (chk_write_i && (chk_idx == '0));
    end

    always_comb begin
        rd_data_o = '0;
        if (chk_idx == '0) begin
            rd_data_o = ID_VALUE;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (chk_idx == IDX_WIDTH'(i)) begin
                rd_data_o = regs_q[i];
            end
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_idx_i == IDX_WIDTH'(i)) begin
                    regs_q[i] <= wr_data_i;
                end
            end
        end
    end

    assign regs_o[DATA_WIDTH-1:0] = ID_VALUE;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs
        assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer for one p_sel slot with a register bank and wait states.
//   pclk, preset          : bus clock, async active-low reset
//   p_sel, p_enable       : select and access-phase strobe
//   p_write, p_addr       : direction and byte address
//   p_wdata               : write data
//   p_rdata               : read data, valid with p_ready on a read
//   p_ready, p_slverr     : completion and error response
//   regs_o                : flat register contents for core logic
//
// state  | meaning
// IDLE   | waiting for a setup phase (p_sel=1, p_enable=0)
// ACCESS | transfer latched; counting wait states, completes when p_ready=1
import apb_pkg::*;

module apb_slave_regfile #(
    parameter int                    NUM_REGS    = N,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA0B0_0001
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic                           p_sel,
    input  logic                           p_enable,
    input  logic                           p_write,
    input  logic [ADDR_WIDTH-1:0]          p_addr,
    input  logic [DATA_WIDTH-1:0]          p_wdata,
    output logic [DATA_WIDTH-1:0]          p_rdata,
    output logic                           p_ready,
    output logic                           p_slverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    apb_slv_state_e        state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  slverr_q, slverr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;

    logic                  setup;
    logic                  commit;
    logic                  chk_err;
    logic [DATA_WIDTH-1:0] rd_data;

    assign setup  = (state_q == IDLE) && p_sel && !p_enable;
    // Writes land only on the completion edge; an abort or reset before it drops them.
    assign commit = (state_q == ACCESS) && p_sel && ready_q && write_q && !err_q;

    apb_regfile #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .pclk        (pclk),
        .preset      (preset),
        .chk_addr_i  (p_addr),
        .chk_write_i (p_write),
        .chk_err_o   (chk_err),
        .rd_data_o   (rd_data),
        .wr_en_i     (commit),
        .wr_idx_i    (idx_q),
        .wr_data_i   (wdata_q),
        .regs_o      (regs_o)
    );

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            rdata_q  <= rdata_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (setup) state_d = ACCESS;
            ACCESS:  if (!p_sel || ready_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = '0;
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        rdata_d  = '0;
        idx_d    = idx_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        if (setup) begin
            idx_d    = p_addr[ADDR_WIDTH-1:WORD_OFFSET_BITS];
            write_d  = p_write;
            wdata_d  = p_wdata;
            err_d    = chk_err;
            cnt_d    = CNT_WIDTH'(WAIT_CYCLES);
            ready_d  = (WAIT_CYCLES == 0);
            slverr_d = chk_err && (WAIT_CYCLES == 0);
            rdata_d  = (!p_write && !chk_err) ? rd_data : '0;
        end else if ((state_q == ACCESS) && p_sel && !ready_q) begin
            cnt_d    = cnt_q - CNT_WIDTH'(1);
            ready_d  = (cnt_q == CNT_WIDTH'(1));
            slverr_d = (cnt_q == CNT_WIDTH'(1)) && err_q;
            rdata_d  = rdata_q;
        end
    end

    always_comb begin
        p_ready  = ready_q;
        p_slverr = slverr_q;
        p_rdata  = rdata_q;
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;

    localparam logic [31:0] ID = 32'hA0B0_0001;
    localparam int NV = 14;

    logic        pclk = 1'b0;
    logic        preset;
    logic [2:0]  p_sel_v;
    logic        p_enable, p_write;
    logic [31:0] p_addr, p_wdata;
    logic [31:0] rdata0, rdata2, rdata3;
    logic [2:0]  ready_v, err_v;
    logic [511:0] regs0, regs2, regs3;

    int n_checks = 0;
    int n_fail   = 0;
    int waits [3] = '{0, 2, 3};

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.WAIT_CYCLES(0)) u_w0 (
        .pclk(pclk), .preset(preset), .p_sel(p_sel_v[0]), .p_enable(p_enable),
        .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(rdata0),
        .p_ready(ready_v[0]), .p_slverr(err_v[0]), .regs_o(regs0));

    apb_slave_regfile #(.WAIT_CYCLES(2)) u_w2 (
        .pclk(pclk), .preset(preset), .p_sel(p_sel_v[1]), .p_enable(p_enable),
        .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(rdata2),
        .p_ready(ready_v[1]), .p_slverr(err_v[1]), .regs_o(regs2));

    apb_slave_regfile #(.WAIT_CYCLES(3)) u_w3 (
        .pclk(pclk), .preset(preset), .p_sel(p_sel_v[2]), .p_enable(p_enable),
        .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(rdata3),
        .p_ready(ready_v[2]), .p_slverr(err_v[2]), .regs_o(regs3));

    typedef struct {
        int          dut;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycles;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb_q [$];

    function automatic logic [31:0] get_rdata(input int d);
        case (d)
            0:       return rdata0;
            1:       return rdata2;
            default: return rdata3;
        endcase
    endfunction

    function automatic logic [31:0] get_reg(input int d, input int i);
        case (d)
            0:       return regs0[i*32 +: 32];
            1:       return regs2[i*32 +: 32];
            default: return regs3[i*32 +: 32];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic go_idle();
        @(posedge pclk); #1;
        p_sel_v  = '0;
        p_enable = 1'b0;
    endtask

    // One APB transfer; compares against the head of the scoreboard when p_ready is seen.
    task automatic run_xfer(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input string tag);
        int   n;
        bit   done;
        exp_t e;
        @(posedge pclk); #1;
        p_sel_v    = '0;
        p_sel_v[d] = 1'b1;
        p_enable   = 1'b0;
        p_write    = wr;
        p_addr     = addr;
        p_wdata    = wdata;
        @(posedge pclk); #1;
        p_enable = 1'b1;
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge pclk);
            n++;
            if (ready_v[d]) done = 1'b1;
            else @(posedge pclk);
        end
        e = sb_q.pop_front();
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout actual=no_ready expected=ready_within_%0d", tag, e.cycles);
            return;
        end
        chk({tag, "_rdata"}, get_rdata(d), e.rdata);
        chk({tag, "_slverr"}, 32'(err_v[d]), 32'(e.err));
        chk({tag, "_cycles"}, 32'(n), 32'(e.cycles));
    endtask

    initial begin
        bit seen;

        vecs[0]  = '{0, 1'b1, 32'h04, 32'h1234_5678, 32'h0,         1'b0};
        vecs[1]  = '{0, 1'b0, 32'h04, 32'h0,         32'h1234_5678, 1'b0};
        vecs[2]  = '{0, 1'b1, 32'h00, 32'hDEAD_BEEF, 32'h0,         1'b1};
        vecs[3]  = '{0, 1'b0, 32'h00, 32'h0,         ID,            1'b0};
        vecs[4]  = '{0, 1'b0, 32'h02, 32'h0,         32'h0,         1'b1};
        vecs[5]  = '{0, 1'b1, 32'h40, 32'hCAFE_F00D, 32'h0,         1'b1};
        vecs[6]  = '{0, 1'b1, 32'h08, 32'h1111_2222, 32'h0,         1'b0};
        vecs[7]  = '{0, 1'b1, 32'h0C, 32'h3333_4444, 32'h0,         1'b0};
        vecs[8]  = '{0, 1'b0, 32'h08, 32'h0,         32'h1111_2222, 1'b0};
        vecs[9]  = '{0, 1'b0, 32'h0C, 32'h0,         32'h3333_4444, 1'b0};
        vecs[10] = '{2, 1'b0, 32'h00, 32'h0,         ID,            1'b0};
        vecs[11] = '{2, 1'b1, 32'h3C, 32'h0F0F_0F0F, 32'h0,         1'b0};
        vecs[12] = '{2, 1'b0, 32'h3C, 32'h0,         32'h0F0F_0F0F, 1'b0};
        vecs[13] = '{2, 1'b0, 32'h44, 32'h0,         32'h0,         1'b1};

        preset   = 1'b0;
        p_sel_v  = '0;
        p_enable = 1'b0;
        p_write  = 1'b0;
        p_addr   = '0;
        p_wdata  = '0;
        #12;
        chk("rst_ready",  32'(ready_v), 32'h0);
        chk("rst_slverr", 32'(err_v), 32'h0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdata3", rdata3, 32'h0);
        chk("rst_w0_reg1", get_reg(0, 1), 32'h0);
        chk("rst_w0_reg0", get_reg(0, 0), ID);
        @(negedge pclk);
        preset = 1'b1;

        // All table transfers run back-to-back with no idle cycles between them.
        for (int i = 0; i < NV; i++) begin
            sb_q.push_back('{vecs[i].exp_rdata, vecs[i].exp_err, waits[vecs[i].dut] + 1});
            run_xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i));
        end
        go_idle();

        chk("w0_reg0_id", get_reg(0, 0), ID);
        chk("w0_reg1", get_reg(0, 1), 32'h1234_5678);
        chk("w0_reg2", get_reg(0, 2), 32'h1111_2222);
        chk("w0_reg3", get_reg(0, 3), 32'h3333_4444);
        for (int i = 4; i < 16; i++) chk($sformatf("w0_reg%0d_zero", i), get_reg(0, i), 32'h0);
        chk("w3_reg15", get_reg(2, 15), 32'h0F0F_0F0F);

        // Abort: p_sel dropped in the second access cycle of a 2-wait write.
        @(posedge pclk); #1;
        p_sel_v = 3'b010; p_enable = 1'b0; p_write = 1'b1; p_addr = 32'h10; p_wdata = 32'h55;
        @(posedge pclk); #1;
        p_enable = 1'b1;
        @(negedge pclk);
        chk("abort_acc1_ready", 32'(ready_v[1]), 32'h0);
        @(posedge pclk); #1;
        p_sel_v = '0; p_enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            if (ready_v[1]) seen = 1'b1;
        end
        chk("abort_ready_seen", 32'(seen), 32'h0);
        chk("abort_reg4", get_reg(1, 4), 32'h0);

        // p_enable high while idle must not start a transfer.
        @(posedge pclk); #1;
        p_sel_v = 3'b010; p_enable = 1'b1; p_write = 1'b1; p_addr = 32'h10; p_wdata = 32'h77;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            if (ready_v[1]) seen = 1'b1;
        end
        chk("idle_enable_ready_seen", 32'(seen), 32'h0);
        chk("idle_enable_reg4", get_reg(1, 4), 32'h0);
        go_idle();

        // regs_o updates only after the completion edge.
        sb_q.push_back('{32'h0, 1'b0, 3});
        run_xfer(1, 1'b1, 32'h18, 32'h0000_ABCD, "w2_wr18");
        chk("regs_o_before_completion", get_reg(1, 6), 32'h0);
        go_idle();
        chk("regs_o_after_completion", get_reg(1, 6), 32'h0000_ABCD);

        // Reset while p_ready is high mid-transfer.
        @(posedge pclk); #1;
        p_sel_v = 3'b010; p_enable = 1'b0; p_write = 1'b1; p_addr = 32'h14; p_wdata = 32'hFF;
        @(posedge pclk); #1;
        p_enable = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        @(negedge pclk);
        chk("rst_mid_ready_before", 32'(ready_v[1]), 32'h1);
        #1 preset = 1'b0;
        #1;
        chk("rst_mid_ready_async", 32'(ready_v[1]), 32'h0);
        chk("rst_mid_w2_reg5", get_reg(1, 5), 32'h0);
        chk("rst_mid_w2_reg6", get_reg(1, 6), 32'h0);
        chk("rst_mid_w0_reg1", get_reg(0, 1), 32'h0);
        chk("rst_mid_w3_reg15", get_reg(2, 15), 32'h0);
        chk("rst_mid_w2_reg0", get_reg(1, 0), ID);
        p_sel_v = '0; p_enable = 1'b0;
        @(negedge pclk);
        preset = 1'b1;

        sb_q.push_back('{32'h0, 1'b0, 3});
        run_xfer(1, 1'b0, 32'h14, 32'h0, "post_rst_rd14");
        sb_q.push_back('{32'h0, 1'b0, 3});
        run_xfer(1, 1'b0, 32'h18, 32'h0, "post_rst_rd18");
        sb_q.push_back('{32'h0, 1'b0, 1});
        run_xfer(0, 1'b0, 32'h04, 32'h0, "post_rst_w0_rd04");
        go_idle();
        repeat (2) @(posedge pclk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
